// File: rtl/sfp_seq_pkg.sv
// Shared types, sizes and helpers for the SFP accumulate/ReLU sequencer.
package sfp_seq_pkg;

  localparam int unsigned N_KIJ_MAX = 9;
  localparam int unsigned N_OUT     = 16;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned OADDR_W   = 4;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD,
    DRAIN,
    RELU,
    WB,
    DONE
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] n_kij;
    logic             relu;
  } cfg_t;

  // Force the accumulation count into 1..N_KIJ_MAX.
  function automatic logic [CNT_W-1:0] clamp_n_kij(input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] r;
    r = n;
    if (n == '0) begin
      r = CNT_W'(1);
    end else if (n > CNT_W'(N_KIJ_MAX)) begin
      r = CNT_W'(N_KIJ_MAX);
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_addr_gen.sv
// Strided psum read-address counter: loads base o, then steps by N_OUT per read.
module psum_addr_gen
  import sfp_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic               step,
  input  logic [OADDR_W-1:0] base,
  output logic [ADDR_W-1:0]  addr
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      addr <= '0;
    end else if (load) begin
      addr <= ADDR_W'(base);
    end else if (step) begin
      addr <= addr + ADDR_W'(N_OUT);
    end
  end

endmodule

// File: rtl/sfp_seq_ctrl.sv
// Sequencer driving clear/accumulate/ReLU/writeback of the SFP for each output pixel.
module sfp_seq_ctrl
  import sfp_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_n_kij,
  input  logic               cfg_relu,
  output logic               busy,
  output logic               done,
  output logic               pmem_ren,
  output logic [ADDR_W-1:0]  pmem_addr,
  output logic               sfp_clr,
  output logic               sfp_acc,
  output logic               sfp_relu,
  output logic               omem_wen,
  output logic [OADDR_W-1:0] omem_addr
);

  state_t             state, state_nxt;
  logic [OADDR_W-1:0] o, o_nxt;
  logic [CNT_W-1:0]   k, k_nxt;
  cfg_t               cfg_q, cfg_nxt;

  logic               busy_nxt, done_nxt, ren_nxt, clr_nxt, acc_nxt, relu_nxt, wen_nxt;
  logic [OADDR_W-1:0] oaddr_nxt;

  psum_addr_gen u_addr (
    .clk   (clk),
    .reset (reset),
    .clear (abort),
    .load  (state == CLR),
    .step  (state == RD),
    .base  (o),
    .addr  (pmem_addr)
  );

  // State, counters, latched config and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      o         <= '0;
      k         <= '0;
      cfg_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pmem_ren  <= 1'b0;
      sfp_clr   <= 1'b0;
      sfp_acc   <= 1'b0;
      sfp_relu  <= 1'b0;
      omem_wen  <= 1'b0;
      omem_addr <= '0;
    end else begin
      state     <= state_nxt;
      o         <= o_nxt;
      k         <= k_nxt;
      cfg_q     <= cfg_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pmem_ren  <= ren_nxt;
      sfp_clr   <= clr_nxt;
      sfp_acc   <= acc_nxt;
      sfp_relu  <= relu_nxt;
      omem_wen  <= wen_nxt;
      omem_addr <= oaddr_nxt;
    end
  end

  // Next state; strobes are decoded from the next state so they register cleanly.
  always_comb begin
    state_nxt = state;
    o_nxt     = o;
    k_nxt     = k;
    cfg_nxt   = cfg_q;

    if (abort) begin
      state_nxt = IDLE;
      o_nxt     = '0;
      k_nxt     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_nxt.n_kij = clamp_n_kij(cfg_n_kij);
            cfg_nxt.relu  = cfg_relu;
            o_nxt         = '0;
            state_nxt     = CLR;
          end
        end
        CLR: begin
          k_nxt     = '0;
          state_nxt = RD;
        end
        RD: begin
          k_nxt = k + CNT_W'(1);
          if (k == CNT_W'(cfg_q.n_kij - CNT_W'(1))) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN:   state_nxt = cfg_q.relu ? RELU : WB;
        RELU:    state_nxt = WB;
        WB: begin
          if (o == OADDR_W'(N_OUT - 1)) begin
            state_nxt = DONE;
          end else begin
            o_nxt     = o + OADDR_W'(1);
            state_nxt = CLR;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt  = (state_nxt != IDLE) && (state_nxt != DONE);
    done_nxt  = (state_nxt == DONE);
    ren_nxt   = (state_nxt == RD);
    clr_nxt   = (state_nxt == CLR);
    // Accumulate trails the read enable by one cycle to line up with read data.
    acc_nxt   = pmem_ren && ((state_nxt == RD) || (state_nxt == DRAIN));
    relu_nxt  = (state_nxt == RELU);
    wen_nxt   = (state_nxt == WB);
    oaddr_nxt = (state_nxt == WB) ? o : '0;
  end

endmodule

// File: tb/tb_sfp_seq_ctrl.sv
// Directed self-checking bench for sfp_seq_ctrl with a psum memory and SFP model in the loop.
module tb_sfp_seq_ctrl;
  import sfp_seq_pkg::*;

  logic               clk;
  logic               reset;
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   cfg_n_kij;
  logic               cfg_relu;
  logic               busy, done, pmem_ren, sfp_clr, sfp_acc, sfp_relu, omem_wen;
  logic [ADDR_W-1:0]  pmem_addr;
  logic [OADDR_W-1:0] omem_addr;

  int n_assert = 0;
  int n_fail   = 0;

  int mem  [0:2047];
  int omem [0:15];
  int rdata;
  int acc_v;

  sfp_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_n_kij (cfg_n_kij),
    .cfg_relu  (cfg_relu),
    .busy      (busy),
    .done      (done),
    .pmem_ren  (pmem_ren),
    .pmem_addr (pmem_addr),
    .sfp_clr   (sfp_clr),
    .sfp_acc   (sfp_acc),
    .sfp_relu  (sfp_relu),
    .omem_wen  (omem_wen),
    .omem_addr (omem_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Psum memory (1-cycle read latency) and SFP accumulator model.
  always @(posedge clk) begin
    if (pmem_ren) rdata <= mem[pmem_addr];
    if (sfp_clr) acc_v <= 0;
    else if (sfp_acc) acc_v <= acc_v + rdata;
    else if (sfp_relu) acc_v <= (acc_v < 0) ? 0 : acc_v;
    if (omem_wen) omem[omem_addr] <= acc_v;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {busy, done, pmem_ren, sfp_clr, sfp_acc, sfp_relu, omem_wen};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, " strobes"}, 32'(strobes()), 32'd0);
    chk({tag, " pmem_addr"}, 32'(pmem_addr), 32'd0);
    chk({tag, " omem_addr"}, 32'(omem_addr), 32'd0);
  endtask

  // Run one tile, checking every cycle against the expected schedule.
  task automatic run_tile(input int cfg_n, input bit relu, input int n_eff,
                          input int abort_o, input string tag);
    int         len;
    logic [6:0] exp;
    len = n_eff + (relu ? 4 : 3);
    cfg_n_kij = CNT_W'(cfg_n);
    cfg_relu  = relu;
    start     = 1'b1;
    step();
    start     = 1'b0;
    for (int o = 0; o < 16; o++) begin
      for (int j = 0; j < len; j++) begin
        exp    = 7'b1000000;
        exp[3] = (j == 0);
        exp[4] = (j >= 1) && (j <= n_eff);
        exp[2] = (j >= 2) && (j <= n_eff + 1);
        exp[1] = relu && (j == n_eff + 2);
        exp[0] = (j == len - 1);
        chk($sformatf("%s strobes o=%0d j=%0d", tag, o, j), 32'(strobes()), 32'(exp));
        if (exp[4])
          chk($sformatf("%s pmem_addr o=%0d j=%0d", tag, o, j), 32'(pmem_addr), 32'((j - 1) * 16 + o));
        if (exp[0])
          chk($sformatf("%s omem_addr o=%0d", tag, o), 32'(omem_addr), 32'(o));
        if (o == 2 && j == 0) begin
          start     = 1'b1;
          cfg_n_kij = CNT_W'(cfg_n + 2);
          cfg_relu  = ~relu;
        end else if (o == 2 && j == 1) begin
          start = 1'b0;
        end
        if (o == abort_o && j == 2) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          chk({tag, " abort next cycle"}, 32'(strobes()), 32'd0);
          for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("%s after abort %0d", tag, i), 32'(strobes()), 32'd0);
          end
          return;
        end
        step();
      end
    end
    chk({tag, " done"}, 32'(strobes()), 32'b0100000);
    step();
    chk({tag, " idle"}, 32'(strobes()), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_n_kij = '0;
    cfg_relu  = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 0;
    for (int i = 0; i < 3; i++) step();
    chk_quiet("reset");
    reset = 1'b1;
    step();
    chk_quiet("post reset idle");

    // Reset in the middle of a run.
    cfg_n_kij = CNT_W'(9);
    cfg_relu  = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("midrun started busy", 32'(busy), 32'd1);
    for (int i = 0; i < 30; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet($sformatf("midrun reset %0d", i));
    end
    reset = 1'b1;
    step();
    chk_quiet("midrun reset release");

    run_tile(9, 1'b1, 9, -1, "n9_relu");
    run_tile(1, 1'b0, 1, -1, "n1_norelu");
    run_tile(0, 1'b0, 1, -1, "clamp0");
    run_tile(15, 1'b1, 9, -1, "clamp15");
    run_tile(2, 1'b0, 2, 5, "abort_o5");

    // Abort and start together in IDLE: start is dropped.
    cfg_n_kij = CNT_W'(3);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort+start idle", 32'(strobes()), 32'd0);
    step();
    chk("abort+start stays idle", 32'(strobes()), 32'd0);

    // Datapath in the loop: o=0 psums {-3,1,1}, o=1 psums {2,-5,1}.
    mem[0] = -3; mem[16] = 1;  mem[32] = 1;
    mem[1] = 2;  mem[17] = -5; mem[33] = 1;
    run_tile(3, 1'b0, 3, -1, "sfp_norelu");
    chk("sfp norelu o0", 32'(omem[0]), 32'(-1));
    chk("sfp norelu o1", 32'(omem[1]), 32'(-2));
    run_tile(3, 1'b1, 3, -1, "sfp_relu");
    chk("sfp relu o0", 32'(omem[0]), 32'd0);
    chk("sfp relu o1", 32'(omem[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
